// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and flag reset values for the synchronous FIFO.
package sync_fifo_pkg;

  localparam logic EMPTY_RST     = 1'b1;
  localparam logic FULL_RST      = 1'b0;
  localparam logic PROG_FULL_RST = 1'b0;

  // Pointer width; a depth of 1 still gets one address bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// FIFO producer/consumer bundle. SYNC_FIFO_STATUS_EN adds overflow/underflow pulses.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  prog_full;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_en;
  logic                  empty;
`ifdef SYNC_FIFO_STATUS_EN
  logic                  overflow;
  logic                  underflow;

  modport master (output wr_data, wr_en, rd_en,
                  input  full, prog_full, rd_data, empty, overflow, underflow);
  modport slave  (input  wr_data, wr_en, rd_en,
                  output full, prog_full, rd_data, empty, overflow, underflow);
`else
  modport master (output wr_data, wr_en, rd_en,
                  input  full, prog_full, rd_data, empty);
  modport slave  (input  wr_data, wr_en, rd_en,
                  output full, prog_full, rd_data, empty);
`endif

endinterface

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write port, registered read port.
module sync_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 10,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array carries no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with registered full/empty/prog_full flags and any depth >= 2.
// Optional SYNC_FIFO_STATUS_EN adds registered overflow/underflow pulses.
module sync_fifo_core
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned BUFFER_DEPTH     = 10,
  parameter int unsigned PROG_FULL_THRESH = BUFFER_DEPTH - 1
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int unsigned PTR_W = ptr_width(BUFFER_DEPTH);
  localparam int unsigned CNT_W = cnt_width(BUFFER_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, empty_q, prog_full_q;
  logic             wr_acc, rd_acc;

  // Pointers wrap at BUFFER_DEPTH-1 rather than at a binary boundary.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_acc = bus.wr_en & ~full_q  & ~rst;
  assign rd_acc = bus.rd_en & ~empty_q & ~rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Flags are derived from the next count so they track the count after each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      empty_q     <= EMPTY_RST;
      full_q      <= FULL_RST;
      prog_full_q <= PROG_FULL_RST;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      empty_q     <= (cnt_d == '0);
      full_q      <= (cnt_d == CNT_W'(BUFFER_DEPTH));
      prog_full_q <= (cnt_d >= CNT_W'(PROG_FULL_THRESH));
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUFFER_DEPTH),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.rd_data)
  );

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.prog_full = prog_full_q;

`ifdef SYNC_FIFO_STATUS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= bus.wr_en & full_q;
      underflow_q <= bus.rd_en & empty_q;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// Randomized and directed bench for sync_fifo_core against a queue-based model.
module tb_sync_fifo_core;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned THR   = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

  sync_fifo_core #(
    .DATA_WIDTH       (DW),
    .BUFFER_DEPTH     (DEPTH),
    .PROG_FULL_THRESH (THR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, last read word, status pulses.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rd   = '0;
  logic          m_ovf  = 1'b0;
  logic          m_unf  = 1'b0;
  logic          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      automatic int sz = mq.size();
      automatic bit wa = bus.wr_en && (sz < DEPTH);
      automatic bit ra = bus.rd_en && (sz > 0);
      m_ovf = bus.wr_en && (sz == DEPTH);
      m_unf = bus.rd_en && (sz == 0);
      if (ra) m_rd = mq.pop_front();
      if (wa) mq.push_back(bus.wr_data);
    end
    chk_en = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("empty",     32'(bus.empty),     32'(mq.size() == 0));
      chk("full",      32'(bus.full),      32'(mq.size() == DEPTH));
      chk("prog_full", 32'(bus.prog_full), 32'(mq.size() >= THR));
      chk("rd_data",   32'(bus.rd_data),   32'(m_rd));
      chk("full_and_empty", 32'(bus.full & bus.empty), 32'd0);
`ifdef SYNC_FIFO_STATUS_EN
      chk("overflow",  32'(bus.overflow),  32'(m_ovf));
      chk("underflow", 32'(bus.underflow), 32'(m_unf));
`endif
    end
  end

  // Drive inputs at a negedge, advance through the posedge, return at the next negedge.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  // Fill with wr_en = ~full starting at value start; returns count written.
  task automatic fill(input logic [DW-1:0] start, output int written);
    automatic logic [DW-1:0] v = start;
    written = 0;
    for (int c = 0; c < 50 && written < DEPTH; c++) begin
      automatic logic w = ~bus.full;
      cyc(w, v, 1'b0);
      if (w) begin
        v++;
        written++;
      end
    end
    chk("fill_count", 32'(written), 32'(DEPTH));
  endtask

  // Drain with rd_en = ~empty, checking the incrementing sequence from start.
  task automatic drain(input logic [DW-1:0] start);
    automatic logic [DW-1:0] v = start;
    automatic int got = 0;
    for (int c = 0; c < 50 && got < DEPTH; c++) begin
      automatic logic r = ~bus.empty;
      cyc(1'b0, 8'hEE, r);
      if (r) begin
        chk("drain_seq", 32'(bus.rd_data), 32'(v));
        v++;
        got++;
      end
    end
    chk("drain_count", 32'(got), 32'(DEPTH));
  endtask

  initial begin
    int n;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    @(negedge clk);
    do_reset(4);
    chk("rst_empty",     32'(bus.empty),     32'd1);
    chk("rst_full",      32'(bus.full),      32'd0);
    chk("rst_prog_full", 32'(bus.prog_full), 32'd0);
    chk("rst_rd_data",   32'(bus.rd_data),   32'd0);

    // Directed fill with flag pinning at 8, 9 and 10 words.
    for (int i = 1; i <= 10; i++) begin
      cyc(~bus.full, 8'(i), 1'b0);
      chk("fill_empty", 32'(bus.empty), 32'd0);
      if (i == 8) chk("pf_at_8", 32'(bus.prog_full), 32'd0);
      if (i == 9) begin
        chk("pf_at_9",   32'(bus.prog_full), 32'd1);
        chk("full_at_9", 32'(bus.full),      32'd0);
      end
    end
    chk("full_at_10", 32'(bus.full), 32'd1);

    // Overflow: writes of 0xFF must be dropped.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 1'b0);
    chk("ovf_full", 32'(bus.full), 32'd1);
    chk("ovf_model_size", 32'(mq.size()), 32'd10);

    drain(8'h01);
    chk("drained_empty", 32'(bus.empty), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    chk("underflow_hold", 32'(bus.rd_data), 32'h0A);

    // Wrap-around: three fill/drain rounds across the pointer wrap.
    for (int r = 0; r < 3; r++) begin
      fill(8'(8'h20 + 10 * r), n);
      drain(8'(8'h20 + 10 * r));
    end

    // Simultaneous read/write at count 5.
    do_reset(1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'(8'h20 + i), 1'b1);
      chk("sim_rd",    32'(bus.rd_data),   32'(8'h10 + i));
      chk("sim_empty", 32'(bus.empty),     32'd0);
      chk("sim_pf",    32'(bus.prog_full), 32'd0);
    end
    chk("sim_size", 32'(mq.size()), 32'd5);
    cyc(1'b0, '0, 1'b1);
    chk("sim_tail0", 32'(bus.rd_data), 32'h14);
    cyc(1'b0, '0, 1'b1);
    chk("sim_tail1", 32'(bus.rd_data), 32'h20);

    // Mid-stream reset discards contents.
    cyc(1'b1, 8'h55, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 8'h66, 1'b1);
    rst = 1'b0;
    chk("midrst_empty", 32'(bus.empty),   32'd1);
    chk("midrst_rd",    32'(bus.rd_data), 32'd0);

    // Random traffic with varying write/read bias and rare resets.
    for (int c = 0; c < 3000; c++) begin
      automatic int ph = (c / 200) % 3;
      automatic int pw = (ph == 0) ? 80 : (ph == 1) ? 50 : 20;
      automatic int pr = (ph == 0) ? 20 : (ph == 1) ? 50 : 80;
      rst = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
    end
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
